// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state encoding and status bit indices (state set depends on ALU_SEQ_TRAP_EN)
package alu_seq_pkg;

    localparam int DATA_W = 20;
    localparam int CNT_W  = 4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_NOT   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHFTL = 4'd5;
    localparam logic [3:0] OP_SHFTR = 4'd6;
    localparam logic [3:0] OP_ROTL  = 4'd7;
    localparam logic [3:0] OP_ROTR  = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_ADD   = 4'd11;
    localparam logic [3:0] OP_ADDC  = 4'd12;
    localparam logic [3:0] OP_SUB   = 4'd13;
    localparam logic [3:0] OP_CMP   = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    localparam int ST_ZERO  = 0;
    localparam int ST_SIGN  = 1;
    localparam int ST_CARRY = 2;
    localparam int ST_TRAP  = 3;

`ifdef ALU_SEQ_TRAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2,
        S_TRAP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHFTL) || (op == OP_SHFTR) || (op == OP_ROTL) || (op == OP_ROTR);
    endfunction

endpackage

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - combinational single-cycle result and carry for logic and arithmetic ops
module alu_seq_exec
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W
)
(
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] flag_val,
    output logic             carry_out,
    output logic             carry_upd,
    output logic             we
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] ext_one;
    logic [WIDTH:0] ext_cin;
    logic [WIDTH:0] sum;

    assign ext_a   = {1'b0, a};
    assign ext_b   = {1'b0, b};
    assign ext_one = {{WIDTH{1'b0}}, 1'b1};
    assign ext_cin = {{WIDTH{1'b0}}, carry_in};

    // Zero-extended add/subtract: bit WIDTH of sum is carry-out, or borrow for subtraction
    always_comb begin
        sum       = '0;
        result    = '0;
        carry_upd = 1'b0;
        we        = 1'b0;
        case (op)
            OP_NOT:  begin result = ~a;    we = 1'b1; end
            OP_AND:  begin result = a & b; we = 1'b1; end
            OP_OR:   begin result = a | b; we = 1'b1; end
            OP_XOR:  begin result = a ^ b; we = 1'b1; end
            OP_INC:  begin sum = ext_a + ext_one;         result = sum[WIDTH-1:0]; carry_upd = 1'b1; we = 1'b1; end
            OP_DEC:  begin sum = ext_a - ext_one;         result = sum[WIDTH-1:0]; carry_upd = 1'b1; we = 1'b1; end
            OP_ADD:  begin sum = ext_a + ext_b;           result = sum[WIDTH-1:0]; carry_upd = 1'b1; we = 1'b1; end
            OP_ADDC: begin sum = ext_a + ext_b + ext_cin; result = sum[WIDTH-1:0]; carry_upd = 1'b1; we = 1'b1; end
            OP_SUB:  begin sum = ext_a - ext_b;           result = sum[WIDTH-1:0]; carry_upd = 1'b1; we = 1'b1; end
            OP_CMP:  begin sum = ext_a - ext_b;           result = a;              carry_upd = 1'b1; end
            default: ;
        endcase
        carry_out = sum[WIDTH];
        // CMP reports a unchanged but derives zero/sign from the difference
        flag_val  = (op == OP_CMP) ? sum[WIDTH-1:0] : result;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - ALU issue controller: op handshake, iterative shifts/rotates, status flags; optional trap via ALU_SEQ_TRAP_EN
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int SHAMT_W = CNT_W
)
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         op_code,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] op_shamt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_we,
    output logic [WIDTH-1:0]   status,
    input  logic               trap_clr
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               accept;
    logic               armed_q;
    logic [WIDTH-1:0]   work_q, work_next;
    logic               shift_out;
    logic [SHAMT_W-1:0] cnt_q;
    logic [3:0]         shop_q;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_we_q;
    logic               zero_q, sign_q, carry_q;

    logic [WIDTH-1:0]   ex_result, ex_flag_val;
    logic               ex_carry, ex_carry_upd, ex_we;

`ifdef ALU_SEQ_TRAP_EN
    logic               trap_q;
`else
    logic               unused_trap_clr;
    assign unused_trap_clr = trap_clr;
`endif

    alu_seq_exec #(.WIDTH(WIDTH)) u_exec (
        .op        (op_code),
        .a         (op_a),
        .b         (op_b),
        .carry_in  (carry_q),
        .result    (ex_result),
        .flag_val  (ex_flag_val),
        .carry_out (ex_carry),
        .carry_upd (ex_carry_upd),
        .we        (ex_we)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state, handshake outputs; DONE with res_ready doubles as an accept slot
    always_comb begin
        state_d   = state_q;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE: op_ready = armed_q;
            S_EXEC: if (cnt_q == CNT_ONE) state_d = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    op_ready = armed_q;
                    state_d  = S_IDLE;
                end
            end
`ifdef ALU_SEQ_TRAP_EN
            S_TRAP: if (trap_clr) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
        accept = op_valid && op_ready;
        if (accept) begin
            if (is_shift(op_code) && (op_shamt != '0)) state_d = S_EXEC;
`ifdef ALU_SEQ_TRAP_EN
            else if (op_code == OP_RSVD)               state_d = S_TRAP;
`endif
            else                                       state_d = S_DONE;
        end
    end

    // One-bit shift/rotate of the working register and the bit that leaves it
    always_comb begin
        work_next = work_q;
        shift_out = 1'b0;
        case (shop_q)
            OP_SHFTL: begin work_next = {work_q[WIDTH-2:0], 1'b0}; shift_out = work_q[WIDTH-1]; end
            OP_SHFTR: begin work_next = {1'b0, work_q[WIDTH-1:1]}; shift_out = work_q[0];       end
            OP_ROTL:  work_next = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            OP_ROTR:  work_next = {work_q[0], work_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    // Datapath: load on accept, iterate in EXEC, capture result and flags on entry into DONE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q    <= 1'b0;
            work_q     <= '0;
            cnt_q      <= '0;
            shop_q     <= OP_NOP;
            res_data_q <= '0;
            res_we_q   <= 1'b0;
            zero_q     <= 1'b0;
            sign_q     <= 1'b0;
            carry_q    <= 1'b0;
`ifdef ALU_SEQ_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            armed_q <= 1'b1;
            if (accept) begin
                if (is_shift(op_code)) begin
                    if (op_shamt != '0) begin
                        work_q <= op_a;
                        cnt_q  <= op_shamt;
                        shop_q <= op_code;
                    end else begin
                        res_data_q <= op_a;
                        res_we_q   <= 1'b1;
                        zero_q     <= (op_a == '0);
                        sign_q     <= op_a[WIDTH-1];
                    end
                end else if ((op_code == OP_NOP) || (op_code == OP_RSVD)) begin
`ifdef ALU_SEQ_TRAP_EN
                    if (op_code == OP_RSVD) begin
                        trap_q <= 1'b1;
                    end else begin
                        res_data_q <= '0;
                        res_we_q   <= 1'b0;
                    end
`else
                    res_data_q <= '0;
                    res_we_q   <= 1'b0;
`endif
                end else begin
                    res_data_q <= ex_result;
                    res_we_q   <= ex_we;
                    zero_q     <= (ex_flag_val == '0);
                    sign_q     <= ex_flag_val[WIDTH-1];
                    if (ex_carry_upd) carry_q <= ex_carry;
                end
            end else if (state_q == S_EXEC) begin
                work_q <= work_next;
                cnt_q  <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_data_q <= work_next;
                    res_we_q   <= 1'b1;
                    zero_q     <= (work_next == '0);
                    sign_q     <= work_next[WIDTH-1];
                    if ((shop_q == OP_SHFTL) || (shop_q == OP_SHFTR)) carry_q <= shift_out;
                end
            end
`ifdef ALU_SEQ_TRAP_EN
            else if ((state_q == S_TRAP) && trap_clr) begin
                trap_q <= 1'b0;
            end
`endif
        end
    end

    // Status word: flags in the low bits, everything above the trap bit reads 0
    always_comb begin
        status           = '0;
        status[ST_ZERO]  = zero_q;
        status[ST_SIGN]  = sign_q;
        status[ST_CARRY] = carry_q;
`ifdef ALU_SEQ_TRAP_EN
        status[ST_TRAP]  = trap_q;
`endif
    end

    assign res_data = res_data_q;
    assign res_we   = res_we_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed table-driven bench for alu_op_sequencer (trap sequence selected by ALU_SEQ_TRAP_EN)
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [19:0] op_a;
    logic [19:0] op_b;
    logic [3:0]  op_shamt;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_data;
    logic        res_we;
    logic [19:0] status;
    logic        trap_clr;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_shamt  (op_shamt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_we    (res_we),
        .status    (status),
        .trap_clr  (trap_clr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [19:0] a;
        logic [19:0] b;
        logic [3:0]  sh;
        logic [19:0] exp_data;
        logic        exp_we;
        logic [19:0] exp_status;
        int          exp_busy;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge: waits for op_ready, presents one op for one edge, counts busy negedges
    task automatic issue(input logic [3:0] op, input logic [19:0] a, input logic [19:0] b,
                         input logic [3:0] sh, output int busy);
        int guard;
        guard = 0;
        while (op_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL issue timeout: op_ready never rose");
        end
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        op_shamt = sh;
        @(posedge clock);
        @(negedge clock);
        op_valid = 1'b0;
        busy = 0;
        while (res_valid !== 1'b1 && busy < 40) begin
            @(negedge clock);
            busy++;
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int busy;

        //            op     a         b         sh    data      we    status  busy
        vecs[0]  = '{4'd11, 20'hFFFFF, 20'h00001, 4'd0,  20'h00000, 1'b1, 20'h5, 0};
        vecs[1]  = '{4'd12, 20'h00001, 20'h00002, 4'd0,  20'h00004, 1'b1, 20'h0, 0};
        vecs[2]  = '{4'd1,  20'h0000F, 20'h00000, 4'd0,  20'hFFFF0, 1'b1, 20'h2, 0};
        vecs[3]  = '{4'd2,  20'hF0F0F, 20'h0FF00, 4'd0,  20'h00F00, 1'b1, 20'h0, 0};
        vecs[4]  = '{4'd3,  20'h80000, 20'h00001, 4'd0,  20'h80001, 1'b1, 20'h2, 0};
        vecs[5]  = '{4'd4,  20'h12345, 20'h12345, 4'd0,  20'h00000, 1'b1, 20'h1, 0};
        vecs[6]  = '{4'd13, 20'h00003, 20'h00005, 4'd0,  20'hFFFFE, 1'b1, 20'h6, 0};
        vecs[7]  = '{4'd4,  20'h00001, 20'h00000, 4'd0,  20'h00001, 1'b1, 20'h4, 0};
        vecs[8]  = '{4'd12, 20'h00000, 20'h00000, 4'd0,  20'h00001, 1'b1, 20'h0, 0};
        vecs[9]  = '{4'd9,  20'hFFFFF, 20'h00000, 4'd0,  20'h00000, 1'b1, 20'h5, 0};
        vecs[10] = '{4'd10, 20'h00000, 20'h00000, 4'd0,  20'hFFFFF, 1'b1, 20'h6, 0};
        vecs[11] = '{4'd10, 20'h00005, 20'h00000, 4'd0,  20'h00004, 1'b1, 20'h0, 0};
        vecs[12] = '{4'd14, 20'h00007, 20'h00007, 4'd0,  20'h00007, 1'b0, 20'h1, 0};
        vecs[13] = '{4'd14, 20'h00002, 20'h00009, 4'd0,  20'h00002, 1'b0, 20'h6, 0};
        vecs[14] = '{4'd6,  20'h00005, 20'h00000, 4'd1,  20'h00002, 1'b1, 20'h4, 1};
        vecs[15] = '{4'd7,  20'h80001, 20'h00000, 4'd3,  20'h0000C, 1'b1, 20'h4, 3};
        vecs[16] = '{4'd5,  20'h00001, 20'h00000, 4'd4,  20'h00010, 1'b1, 20'h0, 4};
        vecs[17] = '{4'd5,  20'h40000, 20'h00000, 4'd2,  20'h00000, 1'b1, 20'h5, 2};
        vecs[18] = '{4'd6,  20'hFFFFF, 20'h00000, 4'd0,  20'hFFFFF, 1'b1, 20'h6, 0};
        vecs[19] = '{4'd8,  20'h00001, 20'h00000, 4'd15, 20'h00020, 1'b1, 20'h4, 15};
        vecs[20] = '{4'd0,  20'h12345, 20'h00000, 4'd0,  20'h00000, 1'b0, 20'h4, 0};
        vecs[21] = '{4'd11, 20'h7FFFF, 20'h00001, 4'd0,  20'h80000, 1'b1, 20'h2, 0};
        vecs[22] = '{4'd13, 20'h00005, 20'h00005, 4'd0,  20'h00000, 1'b1, 20'h1, 0};
        vecs[23] = '{4'd8,  20'h00003, 20'h00000, 4'd1,  20'h80001, 1'b1, 20'h2, 1};

        reset_n   = 1'b0;
        op_valid  = 1'b0;
        op_code   = 4'd0;
        op_a      = 20'h0;
        op_b      = 20'h0;
        op_shamt  = 4'd0;
        res_ready = 1'b0;
        trap_clr  = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset op_ready", {19'd0, op_ready}, 20'd0);
        check("reset res_valid", {19'd0, res_valid}, 20'd0);
        check("reset res_data", res_data, 20'h0);
        check("reset res_we", {19'd0, res_we}, 20'd0);
        check("reset status", status, 20'h0);
        reset_n = 1'b1;
        #1;
        check("op_ready before first edge", {19'd0, op_ready}, 20'd0);
        @(posedge clock);
        #1;
        check("op_ready after first edge", {19'd0, op_ready}, 20'd1);
        @(negedge clock);

        // Table of single ops; flags carry over from one vector to the next
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, busy);
            check($sformatf("vec%0d res_data", i), res_data, vecs[i].exp_data);
            check($sformatf("vec%0d res_we", i), {19'd0, res_we}, {19'd0, vecs[i].exp_we});
            check($sformatf("vec%0d status", i), status, vecs[i].exp_status);
            check($sformatf("vec%0d busy cycles", i), 20'(busy), 20'(vecs[i].exp_busy));
            consume();
        end

        // Reserved opcode 15
`ifdef ALU_SEQ_TRAP_EN
        op_valid = 1'b1;
        op_code  = 4'd15;
        op_a     = 20'h00001;
        @(posedge clock);
        @(negedge clock);
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("trap op_ready", {19'd0, op_ready}, 20'd0);
            check("trap res_valid", {19'd0, res_valid}, 20'd0);
            check("trap status", status, 20'hA);
            @(negedge clock);
        end
        trap_clr = 1'b1;
        @(negedge clock);
        trap_clr = 1'b0;
        check("trap_clr op_ready", {19'd0, op_ready}, 20'd1);
        check("trap_clr status", status, 20'h2);
`else
        issue(4'd15, 20'h00001, 20'h00002, 4'd0, busy);
        check("rsvd res_valid", {19'd0, res_valid}, 20'd1);
        check("rsvd res_data", res_data, 20'h0);
        check("rsvd res_we", {19'd0, res_we}, 20'd0);
        check("rsvd status", status, 20'h2);
        check("rsvd busy cycles", 20'(busy), 20'd0);
        consume();
`endif

        // Hold result under backpressure, then back-to-back accept in the release cycle
        issue(4'd11, 20'hFFFFF, 20'h00001, 4'd0, busy);
        for (int i = 0; i < 5; i++) begin
            check("hold res_valid", {19'd0, res_valid}, 20'd1);
            check("hold res_data", res_data, 20'h00000);
            check("hold status", status, 20'h5);
            check("hold op_ready", {19'd0, op_ready}, 20'd0);
            @(negedge clock);
        end
        res_ready = 1'b1;
        op_valid  = 1'b1;
        op_code   = 4'd1;
        op_a      = 20'h0000F;
        #1;
        check("b2b op_ready", {19'd0, op_ready}, 20'd1);
        @(posedge clock);
        @(negedge clock);
        op_valid  = 1'b0;
        res_ready = 1'b0;
        check("b2b res_valid", {19'd0, res_valid}, 20'd1);
        check("b2b res_data", res_data, 20'hFFFF0);
        check("b2b res_we", {19'd0, res_we}, 20'd1);
        check("b2b status", status, 20'h6);
        consume();

        // Asynchronous reset in the middle of a long rotate
        op_valid = 1'b1;
        op_code  = 4'd8;
        op_a     = 20'h00001;
        op_shamt = 4'd10;
        @(posedge clock);
        @(negedge clock);
        op_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid-rotate busy", {19'd0, res_valid}, 20'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset res_data", res_data, 20'h0);
        check("async reset status", status, 20'h0);
        check("async reset op_ready", {19'd0, op_ready}, 20'd0);
        check("async reset res_valid", {19'd0, res_valid}, 20'd0);
        check("async reset res_we", {19'd0, res_we}, 20'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post-reset op_ready", {19'd0, op_ready}, 20'd1);
        check("post-reset res_valid", {19'd0, res_valid}, 20'd0);
        repeat (12) @(negedge clock);
        check("no stale res_valid", {19'd0, res_valid}, 20'd0);
        issue(4'd11, 20'h00002, 20'h00003, 4'd0, busy);
        check("post-reset add res_data", res_data, 20'h00005);
        check("post-reset add status", status, 20'h0);
        check("post-reset add busy", 20'(busy), 20'd0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
